// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one inter-stage pipeline register: upstream beat,
// downstream beat, flush, and the bubble statistics counter.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_CH*DATA_W-1:0]   in_data;
   logic                       in_ctrl;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_CH*DATA_W-1:0]   out_data;
   logic                       out_ctrl;
   logic                       cnt_clr;
   logic [CNT_W-1:0]           bubble_cnt;

   // Environment side: produces upstream beats and downstream backpressure.
   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready, cnt_clr,
      input  in_ready, out_valid, out_data, out_ctrl, bubble_cnt
   );

   // Pipeline register side.
   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready, cnt_clr,
      output in_ready, out_valid, out_data, out_ctrl, bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main entry M
// drives the outputs, skid entry S absorbs one beat while M is stalled),
// synchronous flush to all-zero bubbles and a saturating bubble counter.
// in_ready depends only on rst, flush and the registered S occupancy, so
// there is no combinational path from out_ready back to in_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_reg_if.slave   bus
);

   localparam int W = NUM_CH * DATA_W;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   logic             m_valid_q, m_valid_d;
   logic [W-1:0]     m_data_q,  m_data_d;
   logic             m_ctrl_q,  m_ctrl_d;
   logic             s_valid_q, s_valid_d;
   logic [W-1:0]     s_data_q,  s_data_d;
   logic             s_ctrl_q,  s_ctrl_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic in_ready;
   logic accept;
   logic fire;

   // A full skid entry or a flush blocks new beats; reset forces not-ready.
   assign in_ready = rst & ~s_valid_q & ~bus.flush;
   assign accept   = bus.in_valid & in_ready;
   assign fire     = m_valid_q & bus.out_ready;

   // Next-state for M and S: S always drains into M before new input does.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;
      if (bus.flush) begin
         // Redirect: every held beat becomes a zero bubble.
         m_valid_d = 1'b0;
         m_data_d  = '0;
         m_ctrl_d  = 1'b0;
         s_valid_d = 1'b0;
         s_data_d  = '0;
         s_ctrl_d  = 1'b0;
      end else if (!m_valid_q || fire) begin
         if (s_valid_q) begin
            // in_ready was low, so nothing new arrives this edge.
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_ctrl_d  = 1'b0;
         end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.in_data;
            m_ctrl_d  = bus.in_ctrl;
         end else begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = 1'b0;
         end
      end else if (accept) begin
         // M is stalled; the beat parks in S (which is empty, since accepted).
         s_valid_d = 1'b1;
         s_data_d  = bus.in_data;
         s_ctrl_d  = bus.in_ctrl;
      end
   end

   // Bubble counter: a cycle where downstream could take a beat but none is held.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if (bus.out_ready && !m_valid_q) begin
         cnt_d = sat_inc(cnt_q);
      end
   end

   // State registers; asynchronous reset drops every beat and the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ctrl_q  <= 1'b0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_ctrl_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_ctrl_q  <= s_ctrl_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = m_valid_q;
   assign bus.out_data   = m_data_q;
   assign bus.out_ctrl   = m_ctrl_q;
   assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: cycle table for pass-through/stall/flush,
// scoreboard over a random phase, counter saturation and mid-stall reset.
module tb_pipe_stage_reg;

   localparam int DW  = 8;
   localparam int NCH = 4;
   localparam int CW  = 4;
   localparam int W   = DW * NCH;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [W-1:0] A = 32'h1111_1111;
   localparam logic [W-1:0] B = 32'h2222_2222;
   localparam logic [W-1:0] C = 32'h3333_3333;
   localparam logic [W-1:0] Z = 32'h0;

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         c;
      logic         ordy;
      logic         fl;
      logic         e_irdy;
      logic         e_ov;
      logic [W-1:0] e_od;
      logic         e_oc;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      logic         c;
   } beat_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;
   beat_t sb[$];
   vec_t  vecs[17];

   pipe_stage_reg_if #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(CW)) bus ();

   pipe_stage_reg #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called just before each active edge: settles handshakes against the queue.
   task automatic mon();
      beat_t b;
      if (!rst) begin
         sb.delete();
         return;
      end
      if (!bus.out_valid) begin
         chk("bubble_data", bus.out_data, 32'h0);
         chk("bubble_ctrl", 32'(bus.out_ctrl), 32'h0);
      end
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no beat", bus.out_data);
         end else begin
            b = sb.pop_front();
            chk("beat_data", bus.out_data, b.d);
            chk("beat_ctrl", 32'(bus.out_ctrl), 32'(b.c));
         end
      end
      if (bus.flush) begin
         sb.delete();
      end else if (bus.in_valid && bus.in_ready) begin
         b.d = bus.in_data;
         b.c = bus.in_ctrl;
         sb.push_back(b);
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      // pass-through
      vecs[0]  = '{H, A, H, H, L,  H,  H, A, H};
      vecs[1]  = '{H, B, L, H, L,  H,  H, B, L};
      vecs[2]  = '{L, Z, L, H, L,  H,  L, Z, L};
      // stall, skid fill, ordered drain
      vecs[3]  = '{H, A, H, L, L,  H,  H, A, H};
      vecs[4]  = '{H, B, L, L, L,  H,  H, A, H};
      vecs[5]  = '{H, C, H, L, L,  L,  H, A, H};
      vecs[6]  = '{H, C, H, H, L,  L,  H, B, L};
      vecs[7]  = '{H, C, H, L, L,  H,  H, B, L};
      vecs[8]  = '{L, Z, L, H, L,  L,  H, C, H};
      vecs[9]  = '{L, Z, L, H, L,  H,  L, Z, L};
      // flush with M and S full and a beat offered
      vecs[10] = '{H, A, H, L, L,  H,  H, A, H};
      vecs[11] = '{H, B, L, L, L,  H,  H, A, H};
      vecs[12] = '{H, C, H, L, H,  L,  L, Z, L};
      vecs[13] = '{L, Z, L, H, L,  H,  L, Z, L};
      // flush concurrent with a downstream fire
      vecs[14] = '{H, A, H, H, L,  H,  H, A, H};
      vecs[15] = '{L, Z, L, H, H,  L,  L, Z, L};
      vecs[16] = '{L, Z, L, H, L,  H,  L, Z, L};

      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_ctrl   = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      bus.cnt_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data",  bus.out_data, 32'h0);
      chk("rst_out_ctrl",  32'(bus.out_ctrl), 32'h0);
      chk("rst_cnt",       32'(bus.bubble_cnt), 32'h0);
      rst = 1'b1;
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 32'h1);

      // table-driven directed cycles
      for (int i = 0; i < 17; i++) begin
         bus.in_valid  = vecs[i].iv;
         bus.in_data   = vecs[i].d;
         bus.in_ctrl   = vecs[i].c;
         bus.out_ready = vecs[i].ordy;
         bus.flush     = vecs[i].fl;
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
         mon();
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d_out_data", i),  bus.out_data, vecs[i].e_od);
         chk($sformatf("v%0d_out_ctrl", i),  32'(bus.out_ctrl), 32'(vecs[i].e_oc));
      end
      bus.flush = 1'b0;

      // random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = $urandom;
         bus.in_ctrl   = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      chk("drain_sb_empty", 32'(sb.size()), 32'h0);
      chk("drain_out_valid", 32'(bus.out_valid), 32'h0);

      // bubble counter: clear, count, saturate, clear-wins, flush-neutral
      bus.cnt_clr = 1'b1;
      step();
      chk("cnt_clr0", 32'(bus.bubble_cnt), 32'h0);
      bus.cnt_clr = 1'b0;
      repeat (3) step();
      chk("cnt_3", 32'(bus.bubble_cnt), 32'h3);
      repeat (17) step();
      chk("cnt_sat", 32'(bus.bubble_cnt), 32'hF);
      bus.cnt_clr = 1'b1;
      step();
      chk("cnt_clr_wins", 32'(bus.bubble_cnt), 32'h0);
      bus.cnt_clr = 1'b0;
      bus.flush   = 1'b1;
      step();
      chk("cnt_flush", 32'(bus.bubble_cnt), 32'h1);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      step();
      chk("cnt_hold", 32'(bus.bubble_cnt), 32'h1);

      // async reset mid-stall with M and S full
      bus.in_valid = 1'b1;
      bus.in_data  = A;
      bus.in_ctrl  = 1'b1;
      step();
      bus.in_data  = B;
      bus.in_ctrl  = 1'b0;
      step();
      chk("pre_rst_in_ready", 32'(bus.in_ready), 32'h0);
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_out_data",  bus.out_data, 32'h0);
      chk("arst_out_ctrl",  32'(bus.out_ctrl), 32'h0);
      chk("arst_in_ready",  32'(bus.in_ready), 32'h0);
      chk("arst_cnt",       32'(bus.bubble_cnt), 32'h0);
      sb.delete();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
      repeat (3) step();
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
